// File: rtl/scan_cycle_ctrl_pkg.sv
// Shared types and helpers for the PLC scan-cycle sequencer.
// WAIT_PERIOD exists only when SCAN_PERIOD_EN is defined.
package scan_cycle_ctrl_pkg;

  localparam int unsigned SCAN_COUNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_IN_SAMPLE   = 3'd1,
    S_EXEC        = 3'd2,
    S_FLUSH       = 3'd3,
    S_OUT_COMMIT  = 3'd4,
`ifdef SCAN_PERIOD_EN
    S_WAIT_PERIOD = 3'd5,
`endif
    S_FAULT       = 3'd6
  } scan_state_e;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_cycle_ctrl_if.sv
// Control/status bundle between the scan sequencer and the fetch/control side.
interface scan_cycle_ctrl_if;
  import scan_cycle_ctrl_pkg::*;

  logic                    run;
  logic                    endOfPgm;
  logic                    pcHalt;
  logic                    pcRestart;
  logic                    inLatchEn;
  logic                    outCommitEn;
  logic                    scanDone;
  logic                    wdtFault;
  logic                    overrun;
  logic [SCAN_COUNT_W-1:0] scanCount;

  modport master (
    output run, endOfPgm,
    input  pcHalt, pcRestart, inLatchEn, outCommitEn, scanDone, wdtFault, overrun, scanCount
  );

  modport slave (
    input  run, endOfPgm,
    output pcHalt, pcRestart, inLatchEn, outCommitEn, scanDone, wdtFault, overrun, scanCount
  );

endinterface

// File: rtl/scan_cycle_ctrl_watchdog.sv
// Saturating up-counter with clear/enable; the top compares against its own terminal values.
// Serves as the EXEC watchdog, the FLUSH timer and the scan-period timer.
module scan_cycle_ctrl_watchdog #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MAX_VALUE = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Saturate so a long-running phase can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/scan_cycle_ctrl.sv
// PLC scan-cycle sequencer: input sample, program run to END, pipeline drain, output commit.
// Optional fixed scan period and overrun reporting when SCAN_PERIOD_EN is defined.
module scan_cycle_ctrl
  import scan_cycle_ctrl_pkg::*;
#(
  parameter int unsigned WDT_CYCLES    = 4096,
  parameter int unsigned FLUSH_CYCLES  = 2
`ifdef SCAN_PERIOD_EN
  ,
  parameter int unsigned PERIOD_CYCLES = 10000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  scan_cycle_ctrl_if.slave bus
);

  localparam int unsigned WDT_W   = cnt_width(WDT_CYCLES);
  localparam int unsigned FLUSH_W = cnt_width(FLUSH_CYCLES);

  scan_state_e             state_q, state_d;
  logic                    pc_halt_q;
  logic                    pc_restart_q;
  logic                    in_latch_q;
  logic                    out_commit_q;
  logic                    wdt_fault_q;
  logic [SCAN_COUNT_W-1:0] scan_count_q;

  logic [WDT_W-1:0]        wdt_cnt;
  logic [FLUSH_W-1:0]      flush_cnt;
  logic                    wdt_last_c;
  logic                    flush_last_c;

  scan_cycle_ctrl_watchdog #(
    .WIDTH     (WDT_W),
    .MAX_VALUE (WDT_CYCLES - 1)
  ) u_wdt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != S_EXEC),
    .en_i  (state_q == S_EXEC),
    .cnt_o (wdt_cnt)
  );

  scan_cycle_ctrl_watchdog #(
    .WIDTH     (FLUSH_W),
    .MAX_VALUE (FLUSH_CYCLES - 1)
  ) u_flush (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != S_FLUSH),
    .en_i  (state_q == S_FLUSH),
    .cnt_o (flush_cnt)
  );

  assign wdt_last_c   = (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
  assign flush_last_c = (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1));

`ifdef SCAN_PERIOD_EN
  localparam int unsigned PER_W = cnt_width(PERIOD_CYCLES);

  logic [PER_W-1:0] period_cnt;
  logic             period_end_c;
  logic             period_late_c;
  logic             overrun_q;

  // Cleared on the edge into IN_SAMPLE so IN_SAMPLE itself reads count 0.
  scan_cycle_ctrl_watchdog #(
    .WIDTH     (PER_W),
    .MAX_VALUE (PERIOD_CYCLES - 1)
  ) u_period (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_d == S_IN_SAMPLE),
    .en_i  (1'b1),
    .cnt_o (period_cnt)
  );

  assign period_end_c  = (period_cnt == PER_W'(PERIOD_CYCLES - 1));
  // Sampled on the FLUSH->OUT_COMMIT edge: the count one cycle later reaches the period end.
  assign period_late_c = (period_cnt >= PER_W'(PERIOD_CYCLES - 2));
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.run) state_d = S_IN_SAMPLE;
      S_IN_SAMPLE: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.endOfPgm) begin
          state_d = S_FLUSH;
        end else if (wdt_last_c) begin
          state_d = S_FAULT;
        end
      end
      S_FLUSH:     if (flush_last_c) state_d = S_OUT_COMMIT;
      S_OUT_COMMIT: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else begin
`ifdef SCAN_PERIOD_EN
          state_d = period_end_c ? S_IN_SAMPLE : S_WAIT_PERIOD;
`else
          state_d = S_IN_SAMPLE;
`endif
        end
      end
`ifdef SCAN_PERIOD_EN
      S_WAIT_PERIOD: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else if (period_end_c) begin
          state_d = S_IN_SAMPLE;
        end
      end
`endif
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_halt_q    <= 1'b1;
      pc_restart_q <= 1'b0;
      in_latch_q   <= 1'b0;
      out_commit_q <= 1'b0;
      wdt_fault_q  <= 1'b0;
      scan_count_q <= '0;
`ifdef SCAN_PERIOD_EN
      overrun_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_halt_q    <= (state_d != S_EXEC);
      pc_restart_q <= (state_d == S_IN_SAMPLE);
      in_latch_q   <= (state_d == S_IN_SAMPLE);
      out_commit_q <= (state_d == S_OUT_COMMIT);
      wdt_fault_q  <= (state_d == S_FAULT);
      if (state_d == S_OUT_COMMIT) begin
        scan_count_q <= scan_count_q + SCAN_COUNT_W'(1);
      end
`ifdef SCAN_PERIOD_EN
      overrun_q    <= (state_d == S_OUT_COMMIT) && period_late_c;
`endif
    end
  end

  assign bus.pcHalt      = pc_halt_q;
  assign bus.pcRestart   = pc_restart_q;
  assign bus.inLatchEn   = in_latch_q;
  assign bus.outCommitEn = out_commit_q;
  assign bus.scanDone    = out_commit_q;
  assign bus.wdtFault    = wdt_fault_q;
  assign bus.scanCount   = scan_count_q;
`ifdef SCAN_PERIOD_EN
  assign bus.overrun     = overrun_q;
`else
  assign bus.overrun     = 1'b0;
`endif

endmodule
